// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write bus of the program loader.
// rx: a byte moves on a rising clk edge when rx_valid && rx_ready; the sender holds rx_data stable until then.
interface imem_loader_if;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready;
  logic        imem_we;
  logic [31:0] imem_addr;
  logic [31:0] imem_wdata;

  modport master (
    output rx_valid, rx_data,
    input  rx_ready, imem_we, imem_addr, imem_wdata
  );

  modport slave (
    input  rx_valid, rx_data,
    output rx_ready, imem_we, imem_addr, imem_wdata
  );
endinterface

// File: rtl/imem_loader.sv
// Boot loader: 16-bit word count then little-endian words, written to imem from address 0.
// Holds the core in reset until every word has been written.
module imem_loader #(
  parameter int ADDR_WIDTH = 10
) (
  input  logic               clk,
  input  logic               rst,
  imem_loader_if.slave       bus,
  input  logic               load_req,
  output logic               core_rst,
  output logic               done,
  output logic               error,
  output logic [2:0]         state_dbg
);

  typedef enum logic [2:0] {
    S_CNT0  = 3'd0,
    S_CNT1  = 3'd1,
    S_DATA  = 3'd2,
    S_WRITE = 3'd3,
    S_DONE  = 3'd4,
    S_ERR   = 3'd5
  } state_e;

  localparam logic [ADDR_WIDTH:0] IDX_ONE = 1;

  state_e              state_q, state_d;
  logic [7:0]          cnt_lo_q, cnt_lo_d;
  logic [15:0]         n_q, n_d;
  logic [ADDR_WIDTH:0] idx_q, idx_d;
  logic [1:0]          byte_idx_q, byte_idx_d;
  logic [23:0]         word_q, word_d;
  logic [31:0]         addr_q, addr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic                core_rst_q, core_rst_d;
  logic                done_q, done_d;
  logic                error_q, error_d;

  logic                rx_ready_c;
  logic                accept;
  logic [15:0]         n_full;

  assign accept = bus.rx_valid && rx_ready_c;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_CNT0;
      cnt_lo_q   <= '0;
      n_q        <= '0;
      idx_q      <= '0;
      byte_idx_q <= '0;
      word_q     <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      core_rst_q <= 1'b1;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_lo_q   <= cnt_lo_d;
      n_q        <= n_d;
      idx_q      <= idx_d;
      byte_idx_q <= byte_idx_d;
      word_q     <= word_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      core_rst_q <= core_rst_d;
      done_q     <= done_d;
      error_q    <= error_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_lo_d   = cnt_lo_q;
    n_d        = n_q;
    idx_d      = idx_q;
    byte_idx_d = byte_idx_q;
    word_d     = word_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    n_full     = {bus.rx_data, cnt_lo_q};

    case (state_q)
      S_CNT0: begin
        if (accept) begin
          cnt_lo_d = bus.rx_data;
          state_d  = S_CNT1;
        end
      end
      S_CNT1: begin
        if (accept) begin
          // N = 2^ADDR_WIDTH is the largest program that fits
          if (n_full == 16'd0 || 32'(n_full) > (32'd1 << ADDR_WIDTH)) begin
            state_d = S_ERR;
          end else begin
            n_d        = n_full;
            idx_d      = '0;
            byte_idx_d = '0;
            state_d    = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (accept) begin
          word_d     = {bus.rx_data, word_q[23:8]};
          byte_idx_d = byte_idx_q + 2'd1;
          if (byte_idx_q == 2'd3) begin
            addr_d  = 32'({idx_q, 2'b00});
            wdata_d = {bus.rx_data, word_q};
            state_d = S_WRITE;
          end
        end
      end
      S_WRITE: begin
        idx_d = idx_q + IDX_ONE;
        if (32'(idx_q) + 32'd1 == 32'(n_q)) state_d = S_DONE;
        else                                 state_d = S_DATA;
      end
      S_DONE: begin
        if (load_req) state_d = S_CNT0;
      end
      S_ERR: begin
        if (load_req) state_d = S_CNT0;
      end
      default: state_d = S_CNT0;
    endcase

    // Status flags are registered copies of the state being entered.
    core_rst_d = (state_d != S_DONE);
    done_d     = (state_d == S_DONE);
    error_d    = (state_d == S_ERR);
  end

  always_comb begin
    rx_ready_c = 1'b0;
    case (state_q)
      S_CNT0, S_CNT1, S_DATA, S_ERR: rx_ready_c = 1'b1;
      default:                       rx_ready_c = 1'b0;
    endcase
    bus.rx_ready   = rx_ready_c;
    bus.imem_we    = (state_q == S_WRITE);
    bus.imem_addr  = addr_q;
    bus.imem_wdata = wdata_q;
    core_rst       = core_rst_q;
    done           = done_q;
    error          = error_q;
    state_dbg      = state_q;
  end

endmodule
